cp0_timer_int: RTL and testbench
================================

// Module: cp0_timer_int
// PURPOSE
//  Interrupt source stage feeding cp0_reg.int_i (-> Cause[15:10]). Holds the CP0 Count/Compare
//  timer and synchronises the five asynchronous hardware interrupt lines.
//  Produces the 6-bit interrupt vector: timer on bit 5 (IP7), external lines on bits 4:0 (IP6..IP2).
//  MTC0/MFC0 to Count/Compare are decoded here, in parallel with cp0_reg.
// PARAMETERS
//  TICK_DIV    2   clock cycles per Count increment (>=1; 1 = every cycle)
//  SYNC_STAGES 2   flop stages on each ext_int_i line (>=2)
// PORTS
//  cpu_clk_50M  in   1   clock, all state on rising edge
//  cpu_rst      in   1   reset, asynchronous, active-high
//  ext_int_i    in   5   hardware interrupt requests, asynchronous, level
//  we           in   1   CP0 write enable (MTC0)
//  waddr        in   5   CP0 write address
//  wdata        in   32  CP0 write data
//  re           in   1   CP0 read enable (MFC0)
//  raddr        in   5   CP0 read address
//  data_o       out  32  read data for Count/Compare, else 0
//  int_o        out  6   {timer_pend, ext_sync[4:0]} -> cp0_reg.int_i
//  timer_int_o  out  1   copy of timer_pend
// BEHAVIOUR
//  - Addresses: `CP0_COUNT = 5'd9, `CP0_COMPARE = 5'd11 (defines.v).
//  - Reset (async, immediate): count=0, compare=0, prescaler=0, timer_pend=0, all sync flops=0;
//    int_o=0, timer_int_o=0, data_o=0 while cpu_rst=1.
//  - Prescaler div counts 0..TICK_DIV-1; tick = (div==TICK_DIV-1); div wraps to 0 on tick.
//  - On tick: count <= count+1, modulo 2^32 (FFFF_FFFF -> 0000_0000, no flag).
//  - Match: on a tick edge where count+1 == compare, timer_pend <= 1 at that same edge.
//    timer_pend is sticky and is set only by a match produced by an increment;
//    a direct write to count or compare that makes count == compare does not set it.
//  - Write compare (we && waddr==`CP0_COMPARE): compare <= wdata, timer_pend <= 0.
//  - Write count (we && waddr==`CP0_COUNT): count <= wdata, div <= 0, and that cycle's tick
//    is dropped.
//  - Simultaneous events in one cycle:
//    - count write + tick: the write wins; no increment; no match set.
//    - compare write + matching tick: the clear wins; timer_pend=0; count still increments.
//  - Write to any other address: ignored here (cp0_reg handles it).
//  - Read: data_o is combinational.
//    - re && raddr==`CP0_COUNT   -> count
//    - re && raddr==`CP0_COMPARE -> compare
//    - otherwise 0
//    - Read in the same cycle as a write returns the old (pre-edge) value.
//  - ext_int_i[i] passes through SYNC_STAGES flops; int_o[i] is the last stage.
//    Latency is SYNC_STAGES rising edges for both assertion and deassertion.
//    Pulses shorter than one clock may be lost.
//  - int_o[5] = timer_pend, registered: it rises at the matching edge and is never combinational.
//  - No state machine beyond prescaler/pending.
//  - Reset asserted mid-count discards everything; counting resumes from 0 on the first edge
//    after release.
// CONFIGURATION
//  CP0_COUNT_STALL_EN defined:
//    - adds input count_stall_i (1 bit), placed after re/raddr.
//    - While count_stall_i=1: prescaler and count hold; no match can set; writes still apply.
//    - Used to freeze the timer during pipeline debug stall.
//  CP0_COUNT_STALL_EN undefined:
//    - the port is absent; count runs freely.
// TESTING
//  1 Reset: run count to 0x37, pulse cpu_rst between edges -> count, compare, int_o, data_o = 0
//    with no clock edge; after release, read Count = 0, then 1 after 2 cycles.
//  2 Timer: write compare=10, then count=0 (TICK_DIV=2) -> int_o[5] rises on the edge where
//    count becomes 10 (20 cycles after the count write) and stays high; write compare=100 ->
//    int_o[5]=0 after the next edge.
//  3 Wrap: write compare=0, then count=FFFF_FFFF -> after 2 cycles count=0, int_o[5]=1;
//    read Count returns 0.
//  4 Collision: count=9, compare=10; on the tick cycle write count=5 -> count=5, int_o[5] stays 0.
//    Repeat with a compare=10 write on the matching tick -> int_o[5]=0.
//  5 External: raise ext_int_i[2] asynchronously -> int_o[2]=1 after exactly 2 edges;
//    drop it -> int_o[2]=0 2 edges later; other bits unchanged.
//  6 Macro: with CP0_COUNT_STALL_EN, hold count_stall_i=1 for 8 cycles -> count unchanged;
//    without the macro, same 8 cycles -> count advances by 4.

Source files
------------

// File: rtl/cp0_timer_int.sv
// CP0 Count/Compare timer plus ext interrupt synchronisers -> int vector.
// Optional CP0_COUNT_STALL_EN adds count_stall_i to freeze the timer.
module cp0_timer_int #(
  parameter int TICK_DIV    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [4:0]  ext_int_i,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [4:0]  raddr,
`ifdef CP0_COUNT_STALL_EN
  input  logic        count_stall_i,
`endif
  output logic [31:0] data_o,
  output logic [5:0]  int_o,
  output logic        timer_int_o
);

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             timer_pend;
  logic [SYNC_STAGES-1:0][4:0] sync;

  logic        run;
  logic        tick;
  logic        count_wr;
  logic        cmp_wr;
  logic [31:0] count_inc;

`ifdef CP0_COUNT_STALL_EN
  assign run = ~count_stall_i;
`else
  assign run = 1'b1;
`endif

  assign tick      = run && (div == DIV_LAST);
  assign count_wr  = we && (waddr == CP0_COUNT);
  assign cmp_wr    = we && (waddr == CP0_COMPARE);
  assign count_inc = count + 32'd1;

  // A count write drops the tick; a compare write beats a match.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      div        <= '0;
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= wdata;
        div   <= '0;
      end else if (run) begin
        div <= tick ? '0 : div + DIV_W'(1);
        if (tick)
          count <= count_inc;
      end
      if (cmp_wr)
        compare <= wdata;
      if (cmp_wr)
        timer_pend <= 1'b0;
      else if (tick && !count_wr && (count_inc == compare))
        timer_pend <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst)
      sync <= '0;
    else
      sync <= {sync[SYNC_STAGES-2:0], ext_int_i};
  end

  always_comb begin
    data_o = '0;
    if (re) begin
      unique case (1'b1)
        raddr == CP0_COUNT:   data_o = count;
        raddr == CP0_COMPARE: data_o = compare;
        default:              data_o = '0;
      endcase
    end
  end

  assign int_o       = {timer_pend, sync[SYNC_STAGES-1]};
  assign timer_int_o = timer_pend;

endmodule

// File: tb/tb_cp0_timer_int.sv
// Directed bench for cp0_timer_int (TICK_DIV=2, SYNC_STAGES=2).
// Inputs change on falling edges; outputs sampled there too.
module tb_cp0_timer_int;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic [4:0]  ext_int_i;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr;
  logic        count_stall_i;
  logic [31:0] data_o;
  logic [5:0]  int_o;
  logic        timer_int_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] v;

  localparam logic [4:0] A_CNT = 5'd9;
  localparam logic [4:0] A_CMP = 5'd11;

  always #5 clk = ~clk;

  cp0_timer_int #(.TICK_DIV(2), .SYNC_STAGES(2)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (cpu_rst),
    .ext_int_i   (ext_int_i),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .re          (re),
    .raddr       (raddr),
`ifdef CP0_COUNT_STALL_EN
    .count_stall_i(count_stall_i),
`endif
    .data_o      (data_o),
    .int_o       (int_o),
    .timer_int_o (timer_int_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; write lands on the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    re = 1'b1;
    raddr = a;
    #1;
    d = data_o;
    re = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1;
    ext_int_i = '0;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    re = 1'b0;
    raddr = '0;
    count_stall_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_int", {26'd0, int_o}, 32'd0);
    rd(A_CNT, v);
    chk("rst_cnt", v, 32'd0);
    @(negedge clk);
    cpu_rst = 1'b0;

    // Reset mid-count, between edges
    ext_int_i = 5'b10000;
    wr(A_CMP, 32'h50);
    wr(A_CNT, 32'h37);
    rd(A_CNT, v);
    chk("pre_rst_cnt", v, 32'h37);
    @(negedge clk);
    chk("pre_rst_ext", {27'd0, int_o[4:0]}, 32'h10);
    #1;
    cpu_rst = 1'b1;
    ext_int_i = '0;
    re = 1'b1;
    raddr = A_CNT;
    #1;
    chk("async_rst_cnt", data_o, 32'd0);
    raddr = A_CMP;
    #1;
    chk("async_rst_cmp", data_o, 32'd0);
    chk("async_rst_int", {26'd0, int_o}, 32'd0);
    chk("async_rst_tmr", {31'd0, timer_int_o}, 32'd0);
    re = 1'b0;
    #1;
    cpu_rst = 1'b0;
    @(negedge clk);
    rd(A_CNT, v);
    chk("post_rst_cnt0", v, 32'd0);
    @(negedge clk);
    rd(A_CNT, v);
    chk("post_rst_cnt1", v, 32'd1);

    // Timer match after 20 cycles
    wr(A_CMP, 32'd10);
    wr(A_CNT, 32'd0);
    repeat (19) @(negedge clk);
    chk("match_pre", {31'd0, int_o[5]}, 32'd0);
    rd(A_CNT, v);
    chk("match_pre_cnt", v, 32'd9);
    @(negedge clk);
    chk("match_hit", {31'd0, int_o[5]}, 32'd1);
    chk("match_tmr", {31'd0, timer_int_o}, 32'd1);
    rd(A_CNT, v);
    chk("match_cnt", v, 32'd10);
    repeat (5) @(negedge clk);
    chk("match_sticky", {31'd0, int_o[5]}, 32'd1);
    wr(A_CMP, 32'd100);
    chk("cmp_clear", {31'd0, int_o[5]}, 32'd0);
    chk("cmp_clear_tmr", {31'd0, timer_int_o}, 32'd0);

    // Wrap FFFF_FFFF -> 0 matches compare=0
    wr(A_CMP, 32'd0);
    wr(A_CNT, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_pre", {31'd0, int_o[5]}, 32'd0);
    @(negedge clk);
    chk("wrap_hit", {31'd0, int_o[5]}, 32'd1);
    rd(A_CNT, v);
    chk("wrap_cnt", v, 32'd0);

    // Direct write equality does not set pending
    wr(A_CMP, 32'd50);
    wr(A_CNT, 32'd50);
    chk("direct_eq", {31'd0, int_o[5]}, 32'd0);
    repeat (2) @(negedge clk);
    chk("direct_eq2", {31'd0, int_o[5]}, 32'd0);

    // Count write collides with matching tick
    wr(A_CMP, 32'd10);
    wr(A_CNT, 32'd9);
    @(negedge clk);
    wr(A_CNT, 32'd5);
    rd(A_CNT, v);
    chk("coll_cnt", v, 32'd5);
    chk("coll_int", {31'd0, int_o[5]}, 32'd0);

    // Compare write collides with matching tick
    wr(A_CNT, 32'd9);
    @(negedge clk);
    wr(A_CMP, 32'd10);
    rd(A_CNT, v);
    chk("coll2_cnt", v, 32'd10);
    chk("coll2_int", {31'd0, int_o[5]}, 32'd0);

    // External interrupt synchroniser
    ext_int_i = 5'b00001;
    repeat (3) @(negedge clk);
    chk("ext_base", {27'd0, int_o[4:0]}, 32'h01);
    #2;
    ext_int_i = 5'b00101;
    @(negedge clk);
    chk("ext_rise1", {27'd0, int_o[4:0]}, 32'h01);
    @(negedge clk);
    chk("ext_rise2", {27'd0, int_o[4:0]}, 32'h05);
    #2;
    ext_int_i = 5'b00001;
    @(negedge clk);
    chk("ext_fall1", {27'd0, int_o[4:0]}, 32'h05);
    @(negedge clk);
    chk("ext_fall2", {27'd0, int_o[4:0]}, 32'h01);

    // Stall window (free running without the macro)
    wr(A_CNT, 32'd100);
    count_stall_i = 1'b1;
    repeat (8) @(negedge clk);
    count_stall_i = 1'b0;
    rd(A_CNT, v);
`ifdef CP0_COUNT_STALL_EN
    chk("stall_cnt", v, 32'd100);
`else
    chk("stall_cnt", v, 32'd104);
`endif

    // Read during write sees old value; other reads are 0
    we = 1'b1;
    waddr = A_CNT;
    wdata = 32'h1234;
    rd(A_CNT, v);
`ifdef CP0_COUNT_STALL_EN
    chk("rdw_old", v, 32'd100);
`else
    chk("rdw_old", v, 32'd104);
`endif
    @(negedge clk);
    we = 1'b0;
    rd(A_CNT, v);
    chk("rdw_new", v, 32'h1234);
    rd(5'd12, v);
    chk("rd_other", v, 32'd0);
    raddr = A_CNT;
    #1;
    chk("rd_noen", data_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
